// File: rtl/vedic_mult_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_mult_pipe_if
//  Description : Stream interface for the pipelined Vedic multiplier.
//                Carries the operand beat (valid/ready, a, b, signed mode,
//                tag), the product beat (valid/ready, product, tag) and the
//                busy status flag.
//                  master : producer/consumer side (drives operands, out_ready)
//                  slave  : multiplier side (drives in_ready, products, busy)
//  Revision    : 1.0  initial release
// ============================================================================
interface vedic_mult_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, busy
    );
endinterface
`default_nettype wire

// File: rtl/vedic_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_mult_pipe
//  Description : Parametrised pipelined Urdhva-Tiryagbhyam multiplier.
//                S0 registers operand magnitudes and the sign of the result,
//                S1 registers all 8x8 leaf products, each following stage
//                merges four quadrant products into one of twice the width.
//                The last stage also applies the conditional negate.
//                A single global enable stalls the whole pipeline when the
//                output beat is held by the consumer.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - stream interface (slave side): operand beat in,
//                        product beat out, busy flag
//  Revision    : 1.0  initial release
// ============================================================================
module vedic_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mult_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH / 8);
    localparam int NB     = WIDTH / 8;      // 8-bit digits per operand
    localparam int F      = LEVELS + 1;     // index of the output stage

    // 8x8 Vedic cell: vertical/crosswise column sums followed by a carry
    // ripple across the 15 columns.
    function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
        logic [3:0]  col [0:14];
        logic [4:0]  acc;
        logic [15:0] p;
        for (int k = 0; k < 15; k++) col[k] = 4'd0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col[4'(i + j)] = col[4'(i + j)] + {3'b000, x[3'(i)] & y[3'(j)]};
            end
        end
        acc = 5'd0;
        p   = 16'd0;
        for (int k = 0; k < 15; k++) begin
            acc       = acc + {1'b0, col[k]};
            p[4'(k)]  = acc[0];
            acc       = acc >> 1;
        end
        p[15] = acc[0];
        return p;
    endfunction

    logic               en;
    logic [F:0]         r_vld;
    logic [TAG_W-1:0]   r_tag [0:F];
    logic [LEVELS:0]    r_neg;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg;

    // Stall only when a real product is being refused; an empty output
    // stage never blocks the pipe from filling.
    assign en           = !(r_vld[F] && !bus.out_ready);
    assign bus.in_ready = en;

    // Negating -2^(W-1) yields 2^(W-1) again, which is its correct
    // unsigned magnitude, so no extra bit is needed.
    always_comb begin
        w_mag_a = bus.in_a;
        w_mag_b = bus.in_b;
        if (bus.in_signed && bus.in_a[WIDTH-1]) w_mag_a = -bus.in_a;
        if (bus.in_signed && bus.in_b[WIDTH-1]) w_mag_b = -bus.in_b;
    end

    assign w_neg = bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);

    // S0 operand register plus the valid/tag shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_a   <= '0;
            r_b   <= '0;
            for (int s = 0; s <= F; s++) r_tag[s] <= '0;
        end else if (en) begin
            r_vld    <= {r_vld[F-1:0], bus.in_valid};
            r_a      <= w_mag_a;
            r_b      <= w_mag_b;
            r_tag[0] <= bus.in_tag;
            for (int s = 1; s <= F; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    // Sign flag only needs to reach the stage that performs the negate.
    if (LEVELS > 0) begin : g_neg_shift
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  r_neg <= '0;
            else if (en) r_neg <= {r_neg[LEVELS-1:0], w_neg};
        end
    end else begin : g_neg_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  r_neg <= '0;
            else if (en) r_neg <= w_neg;
        end
    end

    // Level l holds (NB>>l)^2 products of (8<<l)-bit operand chunks.
    // Chunk (i, j) is digit-group i of a times digit-group j of b.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int PW  = 16 << l;
        localparam int NBL = NB >> l;

        for (genvar i = 0; i < NBL; i++) begin : g_i
            for (genvar j = 0; j < NBL; j++) begin : g_j
                logic [PW-1:0] w_raw;
                logic [PW-1:0] w_fin;
                logic [PW-1:0] r_p;

                if (l == 0) begin : g_leaf
                    assign w_raw = vedic8(r_a[8*i +: 8], r_b[8*j +: 8]);
                end else begin : g_comb
                    localparam int N = 8 << (l - 1);   // sub-chunk operand width
                    logic [2*N-1:0] w_ll, w_lh, w_hl, w_hh;
                    logic [3*N-1:0] w_x, w_y, w_z, w_s, w_c, w_hi;

                    assign w_ll = g_lvl[l-1].g_i[2*i  ].g_j[2*j  ].r_p;
                    assign w_lh = g_lvl[l-1].g_i[2*i  ].g_j[2*j+1].r_p;
                    assign w_hl = g_lvl[l-1].g_i[2*i+1].g_j[2*j  ].r_p;
                    assign w_hh = g_lvl[l-1].g_i[2*i+1].g_j[2*j+1].r_p;

                    // Middle/high part: {HH, LL[high]} + LH + HL, reduced by
                    // a carry-save row and then a single carry-propagate add.
                    // The exact sum fits 3N bits, so the carry-out is dropped.
                    assign w_x  = {w_hh, w_ll[2*N-1:N]};
                    assign w_y  = {{N{1'b0}}, w_lh};
                    assign w_z  = {{N{1'b0}}, w_hl};
                    assign w_s  = w_x ^ w_y ^ w_z;
                    assign w_c  = {(w_x[3*N-2:0] & w_y[3*N-2:0]) |
                                   (w_x[3*N-2:0] & w_z[3*N-2:0]) |
                                   (w_y[3*N-2:0] & w_z[3*N-2:0]), 1'b0};
                    assign w_hi = w_s + w_c;
                    assign w_raw = {w_hi, w_ll[N-1:0]};
                end

                if (l == LEVELS) begin : g_final
                    assign w_fin = r_neg[LEVELS] ? -w_raw : w_raw;
                end else begin : g_pass
                    assign w_fin = w_raw;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)  r_p <= '0;
                    else if (en) r_p <= w_fin;
                end
            end
        end
    end

    assign bus.out_valid = r_vld[F];
    assign bus.out_p     = g_lvl[LEVELS].g_i[0].g_j[0].r_p;
    assign bus.out_tag   = r_tag[F];
    assign bus.busy      = |r_vld;

endmodule
`default_nettype wire

// File: doc/vedic_mult_pipe.md
# vedic_mult_pipe

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. It generalises the fixed-width combinational Vedic tree to any power-of-two operand width from 8 to 64, and adds:
- registered recursion levels,
- a valid/ready stream handshake with back-pressure,
- a per-transaction signed/unsigned mode,
- a pass-through tag.

It sits between operand producers and the accumulator/datapath stages of the 64-bit multiplier subsystem.

## Interface
Parameters:
- WIDTH, 16, operand width; power of two, 8 to 64.
- TAG_W, 4, width of the sideband tag carried alongside each product.
- LEVELS, log2(WIDTH/8), derived; number of recursive combine levels. Not overridable.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  input  TAG_W  sideband, returned unchanged with the product.
- out_valid  output  1  product beat present.
- out_ready  input  1  consumer accepts the beat.
- out_p  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of that product.
- busy  output  1  at least one pipeline stage holds a valid beat.

## Operation
- Stage S0 (input register), on accept (in_valid && in_ready):
  - register |a|, |b|, neg = in_signed & (a[W-1] ^ b[W-1]), and the tag.
  - Magnitude of -2^(W-1) is 2^(W-1), which fits in W unsigned bits.
  - in_signed = 0: operands pass unmodified, neg = 0.
- Stage S1 (leaf products): all (WIDTH/8)^2 8x8 leaf products are computed with the 8x8 Vedic cell and registered.
- Stages S2..S(1+LEVELS) (combine levels): each level merges four N-bit quadrant products into one 2N-bit product, then registers it. The merge uses the standard Vedic combine:
  - low N/2 bits of LL pass directly to the result;
  - middle 3-operand carry-save add of {HH[low], LL[high]}, LH, HL;
  - ripple add of the high half with the carries.
- Final combine stage: applies the conditional two's-complement negate when neg = 1. For WIDTH = 8 (LEVELS = 0) the negate is applied in S1.
- A valid bit and the tag travel with each stage. The busy output is the OR of all stage valid bits.
- Stall: the global enable is en = !(out_valid && !out_ready). When en = 0 every stage holds. Bubbles are not compressed, so the pipeline is a strict shift register.
- in_ready = en. A beat presented while in_ready = 0 is not taken and must be held by the source.
- Ordering: products emerge in acceptance order, one per accepted beat, with no drops and no duplicates.
- Arithmetic:
  - out_p is the exact 2*WIDTH-bit product: unsigned or two's-complement per the in_signed value latched with the beat.
  - There is no truncation and no overflow.
  - Mode may change every beat.

## Timing
- Latency: L = 2 + LEVELS cycles from the accept edge to out_valid (WIDTH=16: 3; WIDTH=64: 5), provided no stall occurs.
- Throughput: one beat per cycle while out_ready = 1.
- out_valid/out_p/out_tag are register outputs and remain stable while out_valid && !out_ready.
- in_ready is combinational from out_ready and out_valid only; there is no path from in_valid.
- Reset (async assert, synchronous deassert expected upstream):
  - all valid bits, out_valid, busy, out_p, and out_tag go to 0 immediately;
  - in_ready reads 1 during and after reset.
- Reset mid-operation discards all in-flight beats, with no partial output.
- An accept and an emit in the same cycle with out_ready = 1 is legal, and the pipeline advances.
- If out_ready = 0 while out_valid = 0, there is no stall: the pipeline fills until a valid beat reaches the output.

## Test plan
- WIDTH=16, unsigned 0xFFFF x 0xFFFF, tag 0x5 -> out_p = 0xFFFE0001, out_tag = 0x5, exactly 3 cycles after accept.
- WIDTH=16, signed 0x8000 x 0x8000 -> 0x40000000; signed 0x8000 x 0x7FFF -> 0xC0008000; signed 0xFFFF x 0x0002 -> 0xFFFFFFFE. The same 0xFFFF x 0x0002 unsigned -> 0x0001FFFE.
- Back-to-back stream of 20 random beats with alternating in_signed and out_ready held 0 for cycles 5-9:
  - in_ready low exactly while stalled;
  - out_p/out_tag frozen;
  - all 20 products correct, in order, no loss.
- Assert rst_n low with 3 beats in flight -> out_valid/busy drop to 0 the same cycle. After release, a new beat 3 x 7 -> 21 with no ghost outputs.
- WIDTH=64, L = 5: random signed/unsigned beats including 0x8000000000000000 squared (= 0x4000...0, 128 bits) -> all match a reference model.
- WIDTH=8, L = 2: exhaustive 65536 unsigned and 65536 signed operand pairs -> all exact.
